// File: rtl/scic_pkg.sv
// scic_pkg: shared opcode, ALU-select and state encodings for the SCIC control unit
package scic_pkg;

    localparam int SCIC_OPCODE_WIDTH = 4;
    localparam int SCIC_ALU_OP_WIDTH = 3;
    localparam int SCIC_STATE_WIDTH  = 4;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_JN    = 4'h8;
    localparam logic [3:0] OP_IN    = 4'h9;
    localparam logic [3:0] OP_OUT   = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_PASS_MEM = 3'd0;
    localparam logic [2:0] ALU_ADD      = 3'd1;
    localparam logic [2:0] ALU_SUB      = 3'd2;
    localparam logic [2:0] ALU_AND      = 3'd3;
    localparam logic [2:0] ALU_PASS_IO  = 3'd4;

    typedef enum logic [SCIC_STATE_WIDTH-1:0] {
        S_WAIT    = 4'd0,
        S_FETCH   = 4'd1,
        S_LOAD_IR = 4'd2,
        S_DECODE  = 4'd3,
        S_MEM_RD  = 4'd4,
        S_EXEC    = 4'd5,
        S_MEM_WR  = 4'd6,
        S_BRANCH  = 4'd7,
        S_IO_OUT  = 4'd8,
        S_HALT    = 4'd9
    } state_t;

    function automatic logic is_illegal(input logic [3:0] op);
        return op inside {[4'hB:4'hE]};
    endfunction

endpackage

// File: rtl/scic_sync_edge.sv
// scic_sync_edge: STAGES-deep synchronizer, optionally followed by a registered rising-edge pulse
//   clock, reset : system clock, async active-high reset
//   d_i          : asynchronous input
//   q_o          : synchronized level (EDGE=0) or one-cycle rising-edge pulse (EDGE=1)
module scic_sync_edge #(
    parameter int STAGES = 2,
    parameter bit EDGE   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    if (EDGE) begin : g_edge
        logic prev_q, pulse_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                prev_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                prev_q  <= sync_q[STAGES-1];
                pulse_q <= sync_q[STAGES-1] & ~prev_q;
            end
        end
        assign q_o = pulse_q;
    end else begin : g_level
        assign q_o = sync_q[STAGES-1];
    end

endmodule

// File: rtl/scic_control_unit.sv
// scic_control_unit: SCIC instruction sequencer with run/single-step gating at instruction boundaries
//   inputs : clock, reset (async, active-high), run (level), step (edge), opcode, ac_zero, ac_neg
//   outputs: datapath strobes (addr_sel, mem_read, mem_write, ir_load, pc_inc, pc_load,
//            ac_load, alu_op, io_read, io_write), halted, illegal_op, state_dbg
module scic_control_unit
    import scic_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int OPCODE_WIDTH = SCIC_OPCODE_WIDTH,
    parameter int ALU_OP_WIDTH = SCIC_ALU_OP_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    step,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    ac_zero,
    input  logic                    ac_neg,
    output logic                    addr_sel,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    ir_load,
    output logic                    pc_inc,
    output logic                    pc_load,
    output logic                    ac_load,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    io_read,
    output logic                    io_write,
    output logic                    halted,
    output logic                    illegal_op,
    output logic [3:0]              state_dbg
);

    state_t state_q, state_d;
    logic   step_pending_q, step_pending_d;
    logic   take_q, take_d;
    logic   illegal_q, illegal_d;
    logic   run_sync, step_pulse;

    scic_sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b0)) u_run_sync (
        .clock(clock), .reset(reset), .d_i(run), .q_o(run_sync)
    );

    scic_sync_edge #(.STAGES(SYNC_STAGES), .EDGE(1'b1)) u_step_sync (
        .clock(clock), .reset(reset), .d_i(step), .q_o(step_pulse)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_WAIT;
            step_pending_q <= 1'b0;
            take_q         <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_pending_q <= step_pending_d;
            take_q         <= take_d;
            illegal_q      <= illegal_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        step_pending_d = step_pending_q | step_pulse;
        take_d         = take_q;
        illegal_d      = 1'b0;
        addr_sel       = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        ir_load        = 1'b0;
        pc_inc         = 1'b0;
        pc_load        = 1'b0;
        ac_load        = 1'b0;
        alu_op         = ALU_PASS_MEM;
        io_read        = 1'b0;
        io_write       = 1'b0;
        halted         = 1'b0;
        case (state_q)
            S_WAIT: begin
                // a step edge coinciding with departure is absorbed by this departure
                if (run_sync | step_pending_q) begin
                    state_d        = S_FETCH;
                    step_pending_d = 1'b0;
                end
            end
            S_FETCH: begin
                mem_read = 1'b1;
                state_d  = S_LOAD_IR;
            end
            S_LOAD_IR: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // flags are captured here so later AC changes cannot alter the branch
                take_d    = (opcode == OP_JMP) | ((opcode == OP_JZ) & ac_zero) | ((opcode == OP_JN) & ac_neg);
                illegal_d = is_illegal(opcode);
                case (opcode)
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND: state_d = S_MEM_RD;
                    OP_STORE:                        state_d = S_MEM_WR;
                    OP_JMP, OP_JZ, OP_JN:            state_d = S_BRANCH;
                    OP_IN:                           state_d = S_EXEC;
                    OP_OUT:                          state_d = S_IO_OUT;
                    OP_HALT:                         state_d = S_HALT;
                    default:                         state_d = S_WAIT;
                endcase
            end
            S_MEM_RD: begin
                addr_sel = 1'b1;
                mem_read = 1'b1;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                ac_load = 1'b1;
                io_read = (opcode == OP_IN);
                alu_op  = (opcode == OP_ADD) ? ALU_ADD :
                          (opcode == OP_SUB) ? ALU_SUB :
                          (opcode == OP_AND) ? ALU_AND :
                          (opcode == OP_IN)  ? ALU_PASS_IO : ALU_PASS_MEM;
                state_d = S_WAIT;
            end
            S_MEM_WR: begin
                addr_sel  = 1'b1;
                mem_write = 1'b1;
                state_d   = S_WAIT;
            end
            S_BRANCH: begin
                pc_load = take_q;
                state_d = S_WAIT;
            end
            S_IO_OUT: begin
                io_write = 1'b1;
                state_d  = S_WAIT;
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_WAIT;
        endcase
    end

    assign illegal_op = illegal_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_scic_control_unit.sv
// tb_scic_control_unit: scoreboard bench for the SCIC sequencer
module tb_scic_control_unit;

    localparam logic [3:0] W = 4'd0, F = 4'd1, L = 4'd2, D = 4'd3, MR = 4'd4;
    localparam logic [3:0] EX = 4'd5, MW = 4'd6, BR = 4'd7, IO = 4'd8, H = 4'd9;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0, step = 1'b0, ac_zero = 1'b0, ac_neg = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       addr_sel, mem_read, mem_write, ir_load, pc_inc, pc_load, ac_load;
    logic [2:0] alu_op;
    logic       io_read, io_write, halted, illegal_op;
    logic [3:0] state_dbg;
    logic [17:0] dv;

    int total = 0;
    int bad = 0;

    scic_control_unit dut (
        .clock(clock), .reset(reset), .run(run), .step(step), .opcode(opcode),
        .ac_zero(ac_zero), .ac_neg(ac_neg), .addr_sel(addr_sel), .mem_read(mem_read),
        .mem_write(mem_write), .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .ac_load(ac_load), .alu_op(alu_op), .io_read(io_read), .io_write(io_write),
        .halted(halted), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    assign dv = {state_dbg, addr_sel, mem_read, mem_write, ir_load, pc_inc, pc_load, ac_load,
                 alu_op, io_read, io_write, halted, illegal_op};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] ev(input logic [3:0] s, input logic [3:0] op, input logic tk, input logic il);
        logic as, mr, mw, ir, pi, pl, al, ior, iow, hl;
        logic [2:0] alu;
        {as, mr, mw, ir, pi, pl, al, ior, iow, hl} = '0;
        alu = 3'd0;
        case (s)
            F:  mr = 1'b1;
            L:  begin ir = 1'b1; pi = 1'b1; end
            MR: begin as = 1'b1; mr = 1'b1; end
            EX: begin
                al  = 1'b1;
                ior = (op == 4'h9);
                alu = (op == 4'h3) ? 3'd1 : (op == 4'h4) ? 3'd2 : (op == 4'h5) ? 3'd3 : (op == 4'h9) ? 3'd4 : 3'd0;
            end
            MW: begin as = 1'b1; mw = 1'b1; end
            BR: pl = tk;
            IO: iow = 1'b1;
            H:  hl = 1'b1;
            default: ;
        endcase
        return {s, as, mr, mw, ir, pi, pl, al, alu, ior, iow, hl, il};
    endfunction

    // drives one instruction, pushes its expected per-cycle outputs, then pops and compares each cycle
    task automatic do_instr(input logic [3:0] op, input logic z, input logic n, input logic flip, input logic stp);
        logic [17:0] sb[$];
        logic [3:0]  tail[$];
        logic        tk, il, found;
        logic [17:0] e;
        tk = (op == 4'h6) | ((op == 4'h7) & z) | ((op == 4'h8) & n);
        il = (op >= 4'hB) && (op <= 4'hE);
        case (op)
            4'h1, 4'h3, 4'h4, 4'h5: tail = '{MR, EX};
            4'h2:                   tail = '{MW};
            4'h6, 4'h7, 4'h8:       tail = '{BR};
            4'h9:                   tail = '{EX};
            4'hA:                   tail = '{IO};
            4'hF:                   tail = '{H};
            default:                tail = '{};
        endcase
        sb.push_back(ev(F, op, tk, 1'b0));
        sb.push_back(ev(L, op, tk, 1'b0));
        sb.push_back(ev(D, op, tk, 1'b0));
        foreach (tail[i]) sb.push_back(ev(tail[i], op, tk, 1'b0));
        if (op != 4'hF) sb.push_back(ev(W, op, tk, il));
        opcode  = op;
        ac_zero = z;
        ac_neg  = n;
        if (stp) step = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 3) step = 1'b0;
            if (state_dbg == F) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        step = 1'b0;
        if (!found) begin
            chk($sformatf("op%0h_fetch_timeout", op), 32'd0, 32'd1);
            return;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (flip && e[17:14] == BR) begin
                ac_zero = ~ac_zero;
                #1;
            end
            chk($sformatf("op%0h_st%0d", op, e[17:14]), {14'd0, dv}, {14'd0, e});
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        run    = 1'b1;
        opcode = 4'h1;
        repeat (2) @(negedge clock);
        chk("reset_outputs", {14'd0, dv}, 32'd0);
        reset = 1'b0;
        do_instr(4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
        do_instr(4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(4'h7, 1'b1, 1'b0, 1'b1, 1'b0);
        do_instr(4'h8, 1'b0, 1'b1, 1'b0, 1'b0);
        do_instr(4'h8, 1'b1, 1'b0, 1'b0, 1'b0);
        do_instr(4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(4'hA, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
        do_instr(4'h9, 1'b0, 1'b0, 1'b0, 1'b0);
        run = 1'b0;
        repeat (20) @(negedge clock);
        chk("paused_state", {28'd0, state_dbg}, {28'd0, W});
        cnt = 0;
        repeat (20) begin
            if (mem_read) cnt++;
            @(negedge clock);
        end
        chk("paused_no_read", cnt, 0);
        do_instr(4'h9, 1'b0, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        repeat (20) begin
            if (mem_read || state_dbg != W) cnt++;
            @(negedge clock);
        end
        chk("step_parks", cnt, 0);
        do_instr(4'hE, 1'b0, 1'b0, 1'b0, 1'b1);
        run = 1'b1;
        do_instr(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step = (i % 6) < 3;
            if (dv === ev(H, 4'hF, 1'b0, 1'b0)) cnt++;
            @(negedge clock);
        end
        step = 1'b0;
        chk("halt_hold", cnt, 50);
        #2 reset = 1'b1;
        #1 chk("async_reset_clears", {14'd0, dv}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        do_instr(4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
